booth_mac_seq: RTL and testbench

//  Sequential radix-4 Booth multiply-accumulate engine for the conv1d datapath.

---
 rtl/booth_mac_seq_pkg.sv | 31 +++
 rtl/booth_mac_seq_digit_pp.sv | 33 +++
 rtl/booth_mac_seq.sv | 115 +++++++++++
 tb/tb_booth_mac_seq.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/booth_mac_seq_pkg.sv
// rtl/booth_mac_seq_pkg.sv - shared widths, FSM states and Booth digit codes for booth_mac_seq
package booth_mac_seq_pkg;

  localparam int WIDTH_DATA_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    DIG_ZERO = 3'd0,
    DIG_POS1 = 3'd1,
    DIG_POS2 = 3'd2,
    DIG_NEG1 = 3'd3,
    DIG_NEG2 = 3'd4
  } booth_dig_t;

  // Radix-4 recoding of {w[2d+1], w[2d], w[2d-1]}
  function automatic booth_dig_t booth_decode(input logic [2:0] grp);
    case (grp)
      3'b001, 3'b010: return DIG_POS1;
      3'b011:         return DIG_POS2;
      3'b100:         return DIG_NEG2;
      3'b101, 3'b110: return DIG_NEG1;
      default:        return DIG_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/booth_mac_seq_digit_pp.sv
// rtl/booth_mac_seq_digit_pp.sv - combinational Booth partial product (booth_digit_pp) at full accumulator width
module booth_digit_pp
  import booth_mac_seq_pkg::*;
#(
  parameter int ACC_W = 20,
  parameter int SH_W  = 4
) (
  input  logic [2:0]       grp,
  input  logic [ACC_W-1:0] mcand,
  input  logic [SH_W-1:0]  shift,
  output logic [ACC_W-1:0] pp
);

  localparam logic [ACC_W-1:0] ONE = ACC_W'(1);

  booth_dig_t       dig;
  logic [ACC_W-1:0] base;

  // Negation happens after shifting so the -2 * most-negative case keeps every bit
  always_comb begin
    dig  = booth_decode(grp);
    base = mcand << shift;
    pp   = '0;
    case (dig)
      DIG_POS1: pp = base;
      DIG_POS2: pp = base << 1;
      DIG_NEG1: pp = ~base + ONE;
      DIG_NEG2: pp = ~(base << 1) + ONE;
      default:  pp = '0;
    endcase
  end

endmodule

// File: rtl/booth_mac_seq.sv
// rtl/booth_mac_seq.sv - sequential radix-4 Booth multiply-accumulate engine, one digit per cycle
module booth_mac_seq
  import booth_mac_seq_pkg::*;
#(
  parameter int WIDTH_DATA = WIDTH_DATA_DEF,
  parameter int ACC_W      = 2 * WIDTH_DATA + 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH_DATA-1:0] in_weight,
  input  logic [WIDTH_DATA-1:0] in_feature,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_W-1:0]      out_acc,
  output logic                  busy
);

  localparam int DIGITS = WIDTH_DATA / 2;
  localparam int CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SH_W   = $clog2(WIDTH_DATA) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGITS - 1);

  state_t                state;
  logic [WIDTH_DATA-1:0] w_q;
  logic [ACC_W-1:0]      f_q;
  logic                  last_q;
  logic [CNT_W-1:0]      cnt;
  logic [ACC_W-1:0]      acc;
  logic [ACC_W-1:0]      pp;
  logic [ACC_W-1:0]      acc_next;
  logic [WIDTH_DATA:0]   w_ext;
  logic [2:0]            grp;
  logic [SH_W-1:0]       shift;

  // Appending a zero supplies the implicit w[-1] for digit 0
  assign w_ext    = {w_q, 1'b0};
  assign grp      = 3'(w_ext >> {cnt, 1'b0});
  assign shift    = SH_W'({cnt, 1'b0});
  assign acc_next = acc + pp;

  booth_digit_pp #(
    .ACC_W (ACC_W),
    .SH_W  (SH_W)
  ) u_pp (
    .grp   (grp),
    .mcand (f_q),
    .shift (shift),
    .pp    (pp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      w_q       <= '0;
      f_q       <= '0;
      last_q    <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_acc   <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            w_q      <= in_weight;
            f_q      <= ACC_W'($signed(in_feature));
            last_q   <= in_last;
            cnt      <= '0;
            state    <= MUL;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        MUL: begin
          acc <= acc_next;
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (last_q) begin
              state     <= DONE;
              out_valid <= 1'b1;
              out_acc   <= acc_next;
            end else begin
              state    <= IDLE;
              in_ready <= 1'b1;
              busy     <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            acc       <= '0;
            out_valid <= 1'b0;
            state     <= IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mac_seq.sv
// tb/tb_booth_mac_seq.sv - directed and randomized self-checking bench for booth_mac_seq
module tb_booth_mac_seq;

  localparam int W  = 8;
  localparam int AW = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_weight;
  logic [W-1:0]  in_feature;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_acc;
  logic          busy;

  int vec_cnt     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int acc_t       = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  booth_mac_seq #(.WIDTH_DATA(W), .ACC_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_weight  (in_weight),
    .in_feature (in_feature),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_acc    (out_acc),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int wrap(input int v);
    logic [AW-1:0] t;
    t = v[AW-1:0];
    return int'($signed(t));
  endfunction

  // Holds in_valid high until the tap is taken; returns at the negedge after the accept edge
  task automatic send(input int w, input int f, input bit l);
    bit ok = 1'b0;
    in_weight  = W'(w);
    in_feature = W'(f);
    in_last    = l;
    in_valid   = 1'b1;
    for (int n = 0; n < 50 && !ok; n++) begin
      if (in_ready) ok = 1'b1;
      @(negedge clk);
    end
    if (!ok) check("accept_timeout", 0, 1);
    else acc_t = cyc;
  endtask

  task automatic collect(input int exp, input string tag, input bit stall);
    bit got = 1'b0;
    for (int n = 0; n < 200 && !got; n++) begin
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && out_ready) begin
        check(tag, $signed(out_acc), exp);
        got = 1'b1;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    if (!got) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic wait_valid(input string tag);
    bit seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      if (out_valid) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) check({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t0;
    int sum;
    int ntaps;
    int w;
    int f;

    rst        = 1'b1;
    in_valid   = 1'b0;
    in_weight  = '0;
    in_feature = '0;
    in_last    = 1'b0;
    out_ready  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_acc", $signed(out_acc), 0);
    rst = 1'b0;
    @(negedge clk);

    send(3, 5, 1'b1);
    in_valid = 1'b0;
    check("mul_busy", busy, 1);
    check("mul_in_ready", in_ready, 0);
    check("mul_out_valid", out_valid, 0);
    wait_valid("lat");
    check("latency", cyc - acc_t, 4);
    collect(15, "w3_f5", 1'b0);
    check("after_out_busy", busy, 0);
    check("after_out_valid", out_valid, 0);

    send(-128, -128, 1'b1);
    in_valid = 1'b0;
    collect(16384, "wneg128_fneg128", 1'b0);
    send(-128, 127, 1'b1);
    in_valid = 1'b0;
    collect(-16256, "wneg128_f127", 1'b0);

    send(1, 2, 1'b0);
    t0 = acc_t;
    send(-3, 4, 1'b0);
    check("tput_1", acc_t - t0, 5);
    t0 = acc_t;
    send(5, -6, 1'b1);
    check("tput_2", acc_t - t0, 5);
    in_valid = 1'b0;
    collect(-40, "three_tap", 1'b0);
    send(2, 3, 1'b1);
    in_valid = 1'b0;
    collect(6, "fresh_window", 1'b0);

    send(-3, 9, 1'b1);
    in_weight  = W'(100);
    in_feature = W'(100);
    in_last    = 1'b1;
    wait_valid("hold");
    for (int i = 0; i < 10; i++) begin
      check("hold_out_valid", out_valid, 1);
      check("hold_out_acc", $signed(out_acc), -27);
      check("hold_in_ready", in_ready, 0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_busy", busy, 0);
    check("release_out_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
    send(1, 1, 1'b1);
    in_valid = 1'b0;
    collect(1, "post_hold_clear", 1'b0);

    send(5, 5, 1'b1);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    send(2, 7, 1'b1);
    in_valid = 1'b0;
    collect(14, "after_rst", 1'b0);

    for (int i = 0; i < 40; i++) send(-128, -128, (i == 39));
    in_valid = 1'b0;
    collect(wrap(40 * 16384), "wrap", 1'b0);

    for (int win = 0; win < 30; win++) begin
      sum   = 0;
      ntaps = int'($urandom_range(1, 4));
      for (int k = 0; k < ntaps; k++) begin
        in_valid = 1'b0;
        repeat (int'($urandom_range(0, 2))) @(negedge clk);
        w = int'($urandom_range(0, 255)) - 128;
        f = int'($urandom_range(0, 255)) - 128;
        sum += w * f;
        send(w, f, (k == ntaps - 1));
      end
      in_valid = 1'b0;
      collect(wrap(sum), "random_window", 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule
